rpc2_ctrl_fifo_sync_arbiter: RTL

//  Shares one rpc2_ctrl_fifo_synchronizer write port between NUM_REQ requesters in the wr_clk domain.

---
 rtl/rpc2_ctrl_pkg.sv | 25 ++
 rtl/rpc2_ctrl_rr_arbiter.sv | 33 +++
 rtl/rpc2_ctrl_fifo_sync_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rpc2_ctrl_pkg.sv
// Shared definitions for rpc2 shared-port controllers: FSM encoding and FIFO word layout.
package rpc2_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Bit position of the last flag in a {last, id, data} FIFO word.
   function automatic int unsigned last_bit(input int unsigned data_width,
                                            input int unsigned id_width);
      return data_width + id_width;
   endfunction

   // Lowest bit of the id field.
   function automatic int unsigned id_lsb(input int unsigned data_width);
      return data_width;
   endfunction

   // Lowest bit of the data field.
   function automatic int unsigned data_lsb();
      return 0;
   endfunction

endpackage

// File: rtl/rpc2_ctrl_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after rr_ptr wins.
module rpc2_ctrl_rr_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic                gnt_valid,
   output logic [ID_WIDTH-1:0] gnt_id
);

   localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   int unsigned idx;

   // Scan from the farthest offset down so the nearest request to rr_ptr is kept last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = 32'(rr_ptr) + 32'(k);
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx[SEL_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_id    = ID_WIDTH'(idx);
         end
      end
   end

endmodule

// File: rtl/rpc2_ctrl_fifo_sync_arbiter.sv
// Round-robin burst arbiter sharing one synchronizer write port; words are tagged {last, id, data}.
module rpc2_ctrl_fifo_sync_arbiter
   import rpc2_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ID_WIDTH       = 2,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                              wr_clk,
   input  logic                              wr_rst_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ-1:0]                req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              fifo_wr_en,
   output logic [DATA_WIDTH+ID_WIDTH:0]      fifo_wr_data,
   input  logic                              fifo_wr_ready,
   output logic [ID_WIDTH-1:0]               grant_id,
   output logic                              busy,
   output logic                              err_timeout
);

   localparam int unsigned FIFO_WIDTH = DATA_WIDTH + ID_WIDTH + 1;
   localparam int unsigned LAST_BIT   = last_bit(DATA_WIDTH, ID_WIDTH);
   localparam int unsigned ID_LSB     = id_lsb(DATA_WIDTH);
   localparam int unsigned DATA_LSB   = data_lsb();
   localparam int unsigned SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t              state_q, state_d;
   logic [ID_WIDTH-1:0]     rr_ptr_q;
   logic                    gnt_valid;
   logic [ID_WIDTH-1:0]     gnt_id;
   logic [SEL_W-1:0]        g_sel;
   logic                    own_valid;
   logic                    own_last;
   logic [DATA_WIDTH-1:0]   own_data;
   logic                    xfer;
   logic [FIFO_WIDTH-1:0]   word;

   rpc2_ctrl_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_arbiter (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Owner's lane selected by the registered grant.
   assign g_sel     = grant_id[SEL_W-1:0];
   assign own_valid = req_valid[g_sel];
   assign own_last  = req_last[g_sel];
   assign own_data  = req_data[g_sel*DATA_WIDTH +: DATA_WIDTH];
   assign busy      = (state_q == LOCK);

   // Word assembly from the layout constants.
   always_comb begin
      word                              = '0;
      word[LAST_BIT]                    = own_last;
      word[ID_LSB +: ID_WIDTH]          = grant_id;
      word[DATA_LSB +: DATA_WIDTH]      = own_data;
   end

   // Next state and the combinational write-port path.
   always_comb begin
      state_d      = state_q;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      xfer         = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = LOCK;
            end
         end
         LOCK: begin
            fifo_wr_en       = own_valid;
            req_ready[g_sel] = fifo_wr_ready;
            fifo_wr_data     = word;
            xfer             = own_valid & fifo_wr_ready;
            if (xfer && own_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_id <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && gnt_valid) begin
            grant_id <= gnt_id;
         end
         if (state_q == LOCK && xfer && own_last) begin
            rr_ptr_q <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
         end
      end
   end

   if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int unsigned      SC_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [SC_W-1:0]  SC_MAX = SC_W'(TIMEOUT_CYCLES - 1);

      logic [SC_W-1:0] stall_cnt;
      logic            stall;

      assign stall = (state_q == LOCK) && !xfer;

      // Stall watchdog: saturating count of transfer-free LOCK cycles, one pulse on reaching the limit.
      always_ff @(posedge wr_clk or negedge wr_rst_n) begin
         if (!wr_rst_n) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
         end else begin
            err_timeout <= stall && (stall_cnt != SC_MAX) && ((stall_cnt + SC_W'(1)) == SC_MAX);
            if (!stall) begin
               stall_cnt <= '0;
            end else if (stall_cnt != SC_MAX) begin
               stall_cnt <= stall_cnt + SC_W'(1);
            end
         end
      end
   end else begin : g_no_wdog
      assign err_timeout = 1'b0;
   end

endmodule
